baw2fixed_preprocessor: RTL

Input-side counterpart of the CeNN output conversion path. Accepts 8-bit RGB pixels over a valid/ready stream, reduces them to luminance, and maps each one to the signed fixed-point CeNN convention: black = +1, white = -1. Applies a user-selectable contrast gain (UP/DOWN buttons, LED level display) with saturation. Emits a one-cycle frame-done pulse after the last pixel of a frame leaves the block. Sits between the pixel source/memory reader and the CeNN core input.

---
 rtl/baw2fixed_preprocessor.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/baw2fixed_preprocessor.sv
// -----------------------------------------------------------------------------
// baw2fixed_preprocessor
//
// Input-side conversion for the CeNN core. RGB pixels arrive on a valid/ready
// stream, are reduced to 8-bit luminance and mapped onto the signed fixed-point
// CeNN range (black = +1, white = -1). A contrast gain of 2^g (g = 0..4) is
// selected with the UP/DOWN buttons and shown on a 5-LED thermometer. The
// result is saturated symmetrically. A one-cycle frame_done pulse follows the
// output handshake of the last pixel of each frame.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   press_UP, press_DOWN  debounced button levels; rising edges step the gain
//   in_valid / in_ready   input pixel handshake
//   pixel_r/g/b           input colour channels (width_RGB bits each)
//   out_valid / out_ready output sample handshake
//   in_cenn               signed fixed-point sample for the CeNN
//   led                   gain level as a thermometer code
//   frame_done            one-cycle end-of-frame pulse
//
// Pipeline: S1 luminance (+ captured gain), S2 signed scale and shift,
// S3 saturation into in_cenn. A single global stall freezes every stage.
// -----------------------------------------------------------------------------
module baw2fixed_preprocessor #(
    parameter int width_fixed = 15,
    parameter int frac_bits   = 12,  // 8 <= frac_bits, width_fixed >= frac_bits + 3
    parameter int width_RGB   = 8,
    parameter int n_pixels    = 4096
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          press_UP,
    input  logic                          press_DOWN,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [width_RGB-1:0]          pixel_r,
    input  logic [width_RGB-1:0]          pixel_g,
    input  logic [width_RGB-1:0]          pixel_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [width_fixed-1:0] in_cenn,
    output logic [4:0]                    led,
    output logic                          frame_done
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int sum_w      = width_RGB + 8;            // 77R+150G+29B never overflows this
    localparam int d_w        = width_RGB + 2;            // signed 255 - 2*gray
    localparam int base_shift = frac_bits - width_RGB;    // places 255 just below 1.0
    localparam int max_gain   = 4;
    localparam int v_need     = d_w + base_shift + max_gain;
    localparam int v_w        = (v_need > width_fixed + 1) ? v_need : width_fixed + 1;
    localparam int cnt_w      = (n_pixels > 1) ? $clog2(n_pixels) : 1;

    localparam logic signed [v_w-1:0] sat_pos = v_w'((2 ** (width_fixed - 1)) - 1);
    localparam logic signed [v_w-1:0] sat_neg = -sat_pos;
    localparam logic [cnt_w-1:0]      cnt_last = cnt_w'(n_pixels - 1);

    typedef logic [2:0] gain_t;

    // ------------------------------------------------------------------
    // Flow control: one global stall, no bubble compression
    // ------------------------------------------------------------------
    logic stall;
    logic advance;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    // Held low while reset is asserted so nothing is offered to a frozen pipe.
    assign in_ready = reset_n && !stall;

    // ------------------------------------------------------------------
    // Gain control: button level -> delayed copy -> registered edge -> g
    // ------------------------------------------------------------------
    logic  up_q, up_qq, up_edge;
    logic  down_q, down_qq, down_edge;
    gain_t gain, gain_next;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge value of its neighbours; blocking here
    // would make the result depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_q      <= 1'b0;
            up_qq     <= 1'b0;
            up_edge   <= 1'b0;
            down_q    <= 1'b0;
            down_qq   <= 1'b0;
            down_edge <= 1'b0;
            gain      <= '0;
        end else begin
            up_q      <= press_UP;
            up_qq     <= up_q;
            up_edge   <= up_q && !up_qq;
            down_q    <= press_DOWN;
            down_qq   <= down_q;
            down_edge <= down_q && !down_qq;
            gain      <= gain_next;
        end
    end

    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    always_comb begin
        gain_next = gain;
        if (up_edge && !down_edge) begin
            if (gain != gain_t'(max_gain)) gain_next = gain + gain_t'(1);
        end else if (down_edge && !up_edge) begin
            if (gain != '0) gain_next = gain - gain_t'(1);
        end
    end

    always_comb begin
        led = 5'b00001;
        case (gain)
            3'd1:    led = 5'b00011;
            3'd2:    led = 5'b00111;
            3'd3:    led = 5'b01111;
            3'd4:    led = 5'b11111;
            default: led = 5'b00001;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath combinational pieces
    // ------------------------------------------------------------------
    logic [sum_w-1:0]           luma_sum;
    logic signed [d_w-1:0]      s1_d;
    logic signed [v_w-1:0]      s1_d_ext;
    logic signed [v_w-1:0]      s1_v;
    logic signed [v_w-1:0]      s2_clamped;

    // S1 input: weighted luminance, weights sum to 256 so white stays white.
    always_comb begin
        luma_sum = sum_w'(77)  * sum_w'(pixel_r)
                 + sum_w'(150) * sum_w'(pixel_g)
                 + sum_w'(29)  * sum_w'(pixel_b);
    end

    // S2 input: map gray to +max..-max and apply the captured gain.
    logic [width_RGB-1:0] s1_gray;
    gain_t                s1_gain;

    always_comb begin
        s1_d     = $signed(d_w'((2 ** width_RGB) - 1)) - $signed({1'b0, s1_gray, 1'b0});
        s1_d_ext = s1_d;  // sign-extends into the wide word
        s1_v     = (s1_d_ext <<< base_shift) <<< s1_gain;
    end

    // S3 input: symmetric saturation; the most negative code is never produced.
    logic signed [v_w-1:0] s2_v;

    always_comb begin
        s2_clamped = s2_v;
        if (s2_v > sat_pos)      s2_clamped = sat_pos;
        else if (s2_v < sat_neg) s2_clamped = sat_neg;
    end

    // ------------------------------------------------------------------
    // Pipeline registers; data registers load bubbles too, only the
    // valid bits carry meaning.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_gray   <= '0;
            s1_gain   <= '0;
            s2_valid  <= 1'b0;
            s2_v      <= '0;
            out_valid <= 1'b0;
            in_cenn   <= '0;
        end else if (advance) begin
            // in_ready is high whenever the pipe advances out of reset
            s1_valid  <= in_valid;
            s1_gray   <= width_RGB'(luma_sum >> 8);
            s1_gain   <= gain;
            s2_valid  <= s1_valid;
            s2_v      <= s1_v;
            out_valid <= s2_valid;
            in_cenn   <= width_fixed'(s2_clamped);
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and end-of-frame pulse
    // ------------------------------------------------------------------
    logic [cnt_w-1:0] pix_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) begin
                if (pix_cnt == cnt_last) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + cnt_w'(1);
                end
            end
        end
    end

endmodule
